// File: rtl/double_to_sig16b_seq.sv
// Iterative IEEE-754 double to signed 16-bit PCM converter with saturation and special-value handling.
// Build option: define ROUND_NEAREST_EN for round-half-to-even; otherwise the result truncates toward zero.
module double_to_sig16b_seq #(
  parameter logic signed [15:0] NAN_VALUE = 16'sh0000,
  parameter int unsigned        PRESHIFT  = 37
) (
  input  logic               clk_operation,
  input  logic               rst,
  input  logic [63:0]        double,
  input  logic               enable,
  output logic signed [15:0] sig16b,
  output logic               ready,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned MANT_W = 53;
  localparam int unsigned WORK_W = MANT_W - PRESHIFT;
  localparam int unsigned MAG_W  = WORK_W + 1;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXP_W  = 11;

  localparam logic [EXP_W-1:0]  EXP_SPECIAL = 11'd2047;
  localparam logic [EXP_W-1:0]  EXP_SAT     = 11'd1038;
  localparam logic [EXP_W-1:0]  EXP_MIN     = 11'd1022;
  localparam logic [MAG_W-1:0]  POS_MAX     = MAG_W'(32767);
  localparam logic [MANT_W-1:0] STICKY_MASK = (MANT_W'(1) << (PRESHIFT - 1)) - MANT_W'(1);

  typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, ROUND} state_t;

  state_t              state_q, state_d;
  logic [63:0]         data_q, data_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                enable_q;
  logic signed [15:0]  sig_d;
  logic                ready_d;
  logic                overrun_d;

  logic                start_c;
  logic                sign_c;
  logic [EXP_W-1:0]    exp_c;
  logic [51:0]         frac_c;
  logic [MANT_W-1:0]   mant_c;
  logic [MANT_W-1:0]   gshift_c;
  logic                inc_c;
  logic [MAG_W-1:0]    mag_c;

  assign start_c  = enable & ~enable_q;
  assign sign_c   = data_q[63];
  assign exp_c    = data_q[62:52];
  assign frac_c   = data_q[51:0];
  assign mant_c   = {1'b1, frac_c};
  assign gshift_c = mant_c >> (PRESHIFT - 1);

`ifdef ROUND_NEAREST_EN
  assign inc_c = guard_q & (sticky_q | work_q[0]);
`else
  assign inc_c = 1'b0;
`endif

  // Magnitude is one bit wider so a round-up from 0xFFFF cannot wrap.
  assign mag_c = MAG_W'(work_q) + MAG_W'(inc_c);

  // State and datapath registers
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      work_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      sig16b   <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      work_q   <= work_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      enable_q <= enable;
      sig16b   <= sig_d;
      ready    <= ready_d;
      busy     <= (state_d != IDLE);
      overrun  <= overrun_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    work_d    = work_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    sig_d     = sig16b;
    ready_d   = 1'b0;
    overrun_d = overrun;

    if (start_c && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_c) begin
          data_d  = double;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if ((exp_c == EXP_SPECIAL) && (frac_c != '0)) begin
          sig_d   = NAN_VALUE;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (exp_c >= EXP_SAT) begin
          sig_d   = sign_c ? 16'sh8000 : 16'sh7FFF;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (exp_c < EXP_MIN) begin
          sig_d   = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          work_d   = WORK_W'(mant_c >> PRESHIFT);
          guard_d  = gshift_c[0];
          sticky_d = |(mant_c & STICKY_MASK);
          cnt_d    = CNT_W'(EXP_SAT - exp_c);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d   = work_q >> 1;
        guard_d  = work_q[0];
        sticky_d = sticky_q | guard_q;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (sign_c) begin
          sig_d = 16'(-mag_c);
        end else if (mag_c > POS_MAX) begin
          sig_d = 16'sh7FFF;
        end else begin
          sig_d = 16'(mag_c);
        end
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_double_to_sig16b_seq.sv
// Scoreboard bench for double_to_sig16b_seq: real-arithmetic reference model, directed plan cases and random doubles.
module tb_double_to_sig16b_seq;

  localparam logic signed [15:0] NAN_V = 16'sh0000;

  typedef struct {
    logic [63:0]        d;
    logic signed [15:0] val;
    int                 cyc;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [63:0]        dbl;
  logic               enable;
  logic signed [15:0] sig16b;
  logic               ready;
  logic               busy;
  logic               overrun;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  double_to_sig16b_seq #(.NAN_VALUE(NAN_V), .PRESHIFT(37)) dut (
    .clk_operation(clk),
    .rst          (rst),
    .double       (dbl),
    .enable       (enable),
    .sig16b       (sig16b),
    .ready        (ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: real-valued rounding of the magnitude, then sign and saturation.
  function automatic logic signed [15:0] model_val(input logic [63:0] d);
    real a, fl, fr;
    int  k;
    if ((d[62:52] == 11'h7FF) && (d[51:0] != 52'd0)) return NAN_V;
    a = $bitstoreal({1'b0, d[62:0]});
    if (a >= 32768.0) return d[63] ? -16'sd32768 : 16'sd32767;
    fl = $floor(a);
    fr = a - fl;
    k  = $rtoi(fl);
`ifdef ROUND_NEAREST_EN
    if ((fr > 0.5) || ((fr == 0.5) && ((k % 2) == 1))) k = k + 1;
`else
    if (fr < 0.0) k = 0;
`endif
    if (!d[63] && (k > 32767)) k = 32767;
    return d[63] ? 16'(-k) : 16'(k);
  endfunction

  function automatic int model_lat(input logic [63:0] d);
    int e;
    e = int'(d[62:52]);
    if ((e >= 1038) || (e < 1022)) return 1;
    return 2 + (1038 - e);
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input int k);
    exp_t x;
    x.d   = d;
    x.val = model_val(d);
    x.cyc = k + model_lat(d);
    return x;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_ready: got ready with sig16b=%0d, expected no pulse (t=%0t)", sig16b, $time);
        end else begin
          x = sb.pop_front();
          check($sformatf("value[%h]", x.d), int'(sig16b), int'(x.val));
          check($sformatf("latency[%h]", x.d), cyc, x.cyc);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout_%s: busy still %b after 60 cycles, expected 0", name, busy);
  endtask

  task automatic convert(input logic [63:0] d);
    wait_idle("pre");
    dbl    = d;
    enable = 1'b1;
    sb.push_back(mk(d, cyc + 1));
    @(negedge clk);
    enable = 1'b0;
    wait_idle("conv");
  endtask

  function automatic logic [63:0] rand_double();
    logic [63:0] rr;
    logic [51:0] frac;
    logic [10:0] e;
    int unsigned r;
    r  = $urandom_range(0, 15);
    rr = {$urandom(), $urandom()};
    frac = rr[51:0];
    if (r == 0)      e = 11'd2047;
    else if (r == 1) e = 11'd0;
    else             e = 11'($urandom_range(1012, 1045));
    if ($urandom_range(0, 2) == 0) frac = frac & ~((52'd1 << $urandom_range(0, 51)) - 52'd1);
    return {1'($urandom_range(0, 1)), e, frac};
  endfunction

  logic [63:0] plan [10];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    enable = 1'b0;
    dbl    = '0;
    plan = '{64'h40934A0000000000, 64'hBFF8000000000000, 64'h40E3880000000000,
             64'hC0E3880000000000, 64'h40DFFFF000000000, 64'h7FF8000000000000,
             64'h7FF0000000000000, 64'h3FD0000000000000, 64'h8000000000000000,
             64'h3FE8000000000000};

    repeat (2) @(negedge clk);
    check("rst_sig16b", int'(sig16b), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (plan[i]) convert(plan[i]);

    // Enable held high for several cycles: one conversion only.
    dbl    = 64'h40934A0000000000;
    enable = 1'b1;
    sb.push_back(mk(dbl, cyc + 1));
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_idle("hold");
    check("hold_overrun", int'(overrun), 0);

    // Second rising edge while busy is dropped and sets overrun.
    dbl    = 64'hBFF8000000000000;
    enable = 1'b1;
    sb.push_back(mk(dbl, cyc + 1));
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    dbl    = 64'h40E3880000000000;
    enable = 1'b1;
    @(negedge clk);
    check("ovr_set", int'(overrun), 1);
    check("ovr_busy", int'(busy), 1);
    enable = 1'b0;
    wait_idle("ovr");
    check("ovr_sticky", int'(overrun), 1);
    convert(64'h40E3880000000000);
    check("ovr_after", int'(overrun), 1);

    for (int i = 0; i < 200; i++) convert(rand_double());

    // Asynchronous reset during SHIFT, with enable held high through release.
    convert(64'h40934A0000000000);
    dbl    = 64'h3FF0000000000000;
    enable = 1'b1;
    sb.push_back(mk(dbl, cyc + 1));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("arst_sig16b", int'(sig16b), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(ready), 0);
    check("arst_overrun", int'(overrun), 0);
    repeat (3) @(negedge clk);
    dbl = 64'h40934A0000000000;
    rst = 1'b1;
    sb.push_back(mk(dbl, cyc + 1));
    @(negedge clk);
    enable = 1'b0;
    wait_idle("arst");
    check("arst_overrun_after", int'(overrun), 0);

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/double_to_sig16b_seq.md
Name: double_to_sig16b_seq

Overview:
Sequential IEEE-754 double to signed 16-bit PCM converter for the output path of the echo canceller. It is the return leg of the sig16b_to_double front end: it takes the canceller's double-precision result and produces a 16-bit sample for the DAC side. It uses an iterative shift-based datapath with rounding, saturation and special-value handling, trading latency (max 18 cycles) for area. It runs on clk_operation, which is far faster than the sample rate.

Parameters:
NAN_VALUE, 16'sh0000, output value loaded when the input is NaN.
PRESHIFT, 37, fixed coarse right shift applied in UNPACK. Not intended to change; the latency figures below assume 37.

Ports:
clk_operation  input  1  operating clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
double  input  64  IEEE-754 double; integer-scaled sample (1234.0 means sample 1234). Captured on accepted start.
enable  input  1  start request; rising-edge detected, so it may be held high for several cycles.
sig16b  output  16  signed result; holds its value until the next completion.
ready  output  1  one-cycle pulse, asserted in the cycle sig16b updates.
busy  output  1  high whenever state != IDLE.
overrun  output  1  sticky; set when a start request is dropped because the block is busy. Cleared only by reset.

Behaviour:
- Reset (rst=0, async): state=IDLE; sig16b=0, ready=0, busy=0, overrun=0; enable-history register=0.
  - Consequence: enable already high when reset releases counts as a rising edge.
  - Reset mid-conversion aborts with no ready pulse.
- Start detection: start = enable & ~enable_q.
  - Start in IDLE: capture double, go to UNPACK.
  - Start in any other state: ignored, overrun<=1.
- ready is 0 in every cycle except the completion cycle.
- Notation: s = double[63], e = double[62:52], m = {1, double[51:0]}.
- FSM IDLE -> UNPACK -> (SHIFT -> ROUND | IDLE) -> IDLE.
- UNPACK (capture edge k, evaluated at edge k+1). Specials complete at edge k+1: sig16b loaded, ready=1, go to IDLE.
  - e=2047 with frac!=0 (NaN): sig16b=NAN_VALUE.
  - e=2047 with frac=0 (Inf): saturate.
  - e>=1038: saturate; s=0 gives 32767, s=1 gives -32768.
  - e<1022 (includes zero, -0 and denormals): sig16b=0.
  - Otherwise (1022<=e<=1037):
    - Load m>>PRESHIFT into the working register.
    - guard=m[36]; sticky=|m[35:0].
    - cnt = 1038-e (range 1..16); go to SHIFT.
- SHIFT: each edge shifts right by 1.
  - guard <= lsb.
  - sticky <= sticky|guard.
  - cnt--.
  - Leave to ROUND on the edge where cnt becomes 0.
- ROUND: magnitude q (17 bits, max 65535 before increment).
  - Round half to even: increment if guard & (sticky | q[0]).
  - Apply sign.
  - Clamp: positive >32767 gives 32767; negative magnitude >32768 cannot occur.
  - Load sig16b, ready=1, go to IDLE.
- Latency from capture edge k:
  - Special values: ready after edge k+1.
  - Normal values: ready after edge k+2+n, where n=1038-e. Maximum is k+18.
- A start coincident with the ROUND/special completion edge is dropped and sets overrun.
- A start is accepted on the first edge with state=IDLE.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round-half-to-even as described under ROUND.
- Undefined: truncate toward zero; guard and sticky are ignored.
  - Saturation, specials and latency are unchanged.
  - The 17-bit overflow clamp is still present.

Test Plan:
1. double=0x40934A0000000000 (1234.5), enable rising at edge k -> ready pulse after edge k+7; sig16b=1234 (1234 with truncation).
2. double=0xBFF8000000000000 (-1.5) -> sig16b=-2 (0xFFFE) after k+17; truncation gives -1.
3. 0x40E3880000000000 (40000.0) -> 32767 after k+1; 0xC0E3880000000000 -> -32768 (0x8000) after k+1; 0x40DFFFF000000000 (32767.75) -> 32767 via post-round clamp.
4. Specials:
   - 0x7FF8000000000000 (NaN) -> NAN_VALUE (0).
   - 0x7FF0000000000000 (+Inf) -> 32767.
   - 0x3FD0000000000000 (0.25) -> 0.
   - 0x8000000000000000 (-0) -> 0.
   - All complete after k+1.
5. Protocol:
   - Hold enable high for 5 cycles -> exactly one conversion and one ready pulse.
   - Second rising edge issued while busy -> ignored, overrun=1 and stays 1.
   - The next accepted conversion completes normally.
6. Drive rst=0 asynchronously mid-SHIFT (between clock edges) -> sig16b=0, busy=0, ready=0, overrun=0 immediately; no ready pulse follows. After release, enable already high starts a new conversion.
